// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Definitions shared by the single-issue MIPS core front end and its Control
// decoder: the reset PC, the PC increment, the position of the opcode field,
// the opcode encodings, and the {pc, instr} entry held in the fetch queue.
// -----------------------------------------------------------------------------
package core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Opcode field position inside an instruction word
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;

    typedef enum logic [OP_W-1:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_ORI   = 6'b001101,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [OP_W-1:0] opcode_of(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// In-order queue of fetched {pc, instr} entries between instruction memory and
// decode. Flush empties the queue and takes priority over push and pop.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (pointers and count only)
//   flush      discard all entries
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        remove the head entry (ignored when empty)
//   head       head entry (undefined contents when empty)
//   count      number of valid entries
//   empty      count == 0
//   full       count == DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import core_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full queue can still accept.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; validity comes only from count, so resetting
    // the array would just add reset fan-out to every data flop.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: reset is synchronous, sampled only on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Front end of the single-issue MIPS core. Owns the PC, issues word fetches to
// instruction memory under a credit limit, buffers returned words in order and
// presents them to decode with a valid/ready handshake. A redirect from EX
// flushes the queue, reloads the PC and discards words still in flight.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   imem_req_o/addr_o       fetch request and word-aligned address (= pc)
//   imem_gnt_i              request accepted this cycle
//   imem_rvalid_i/rdata_i   in-order read response
//   redirect_i/redirect_pc_i  flush and new PC (low two bits ignored)
//   instr_valid_o           queue head valid
//   dec_ready_i             decode takes the head this cycle
//   instr_o, pc_o, op_o     head instruction, its PC, its opcode field
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter  logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter  int unsigned DEPTH    = 2,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [31:0]     imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [31:0]     redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            dec_ready_i,
    output logic [31:0]     instr_o,
    output logic [31:0]     pc_o,
    output logic [OP_W-1:0] op_o
);

    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

    logic [31:0]      pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   in_use;
    logic [31:0]      redirect_target;
    logic             grant;
    logic             accept;
    logic             pop;
    logic             empty;
    logic             full;
    fetch_entry_t     head;
    fetch_entry_t     push_data;
    logic             unused;

    assign redirect_target = {redirect_pc_i[31:2], 2'b00};

    // Queued words plus words in flight never exceed DEPTH, so every response
    // has a free slot and the queue cannot overflow. The request is also held
    // off while reset is asserted so nothing is issued before the PC is valid.
    assign in_use      = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_o  = rst_i && !redirect_i && (in_use < CREDITS);
    assign imem_addr_o = pc;
    assign grant       = imem_req_o && imem_gnt_i;

    // Responses that belong to pre-redirect requests are dropped by drop_cnt;
    // a response arriving in the redirect cycle itself is dropped directly.
    assign accept    = imem_rvalid_i && !redirect_i && (drop_cnt == '0);
    assign push_data = '{pc: resp_pc, instr: imem_rdata_i};

    assign instr_valid_o = !empty;
    assign pop           = instr_valid_o && dec_ready_i && !redirect_i;

    // Outputs come from registered queue storage and are zeroed when the queue
    // is empty, so stale storage never shows on the decode interface.
    assign instr_o = empty ? '0 : head.instr;
    assign pc_o    = empty ? '0 : head.pc;
    assign op_o    = opcode_of(instr_o);

    assign unused = ^{full, redirect_pc_i[1:0]};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .flush     (redirect_i),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
            if (redirect_i) begin
                // Every request still in flight after this edge is stale.
                pc       <= redirect_target;
                resp_pc  <= redirect_target;
                drop_cnt <= outstanding - CNT_W'(imem_rvalid_i);
            end else begin
                if (grant) begin
                    pc <= pc + PC_STEP;
                end
                if (imem_rvalid_i) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - CNT_W'(1);
                    end else begin
                        resp_pc <= resp_pc + PC_STEP;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Drives instr_fetch_unit with a behavioural instruction memory of adjustable
// latency. Every word the memory returns that decode should see is queued as
// an expected {pc, instr}; each decode handshake pops and compares. Directed
// sequences cover reset, decode stall, grant stall, redirect with in-flight
// requests, PC wrap and reset with a full queue.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import core_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        dec_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [5:0]  op_o;

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .dec_ready_i   (dec_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .op_o          (op_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    req_t        inflight[$];
    exp_t        exp_q[$];
    int          n_checks    = 0;
    int          n_pass      = 0;
    int          cyc         = 0;
    int          lat         = 1;
    int          grants      = 0;
    logic [31:0] exp_next_pc = RST_PC;
    logic [31:0] last_grant  = '0;
    bit          check_lw    = 1'b1;
    bit          check_first = 1'b0;
    logic [31:0] first_pc    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Memory contents: the reset PC holds a lw, other words carry a mix of
    // opcodes and their own word address so misordering is visible.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [5:0] op;
        if (a == RST_PC) return 32'h8C01_0004;
        case (a[4:2])
            3'd0:    op = OP_LW;
            3'd1:    op = OP_RTYPE;
            3'd2:    op = OP_SW;
            3'd3:    op = OP_ORI;
            3'd4:    op = OP_BEQ;
            3'd5:    op = 6'h02;
            3'd6:    op = 6'h0F;
            default: op = 6'h3F;
        endcase
        return {op, a[27:2]};
    endfunction

    // One clock cycle, entered and left just after a falling edge. Control
    // inputs for the coming rising edge are already set by the caller.
    task automatic cycle();
        req_t r;
        exp_t e;
        bit   resp;
        resp = 1'b0;
        r    = '{addr: '0, due: 0, stale: 1'b0};
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (!rst_i) begin
            inflight.delete();
            exp_q.delete();
        end else if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            r    = inflight.pop_front();
            resp = 1'b1;
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(r.addr);
        end
        #1;
        if (!rst_i) begin
            exp_next_pc = RST_PC;
        end else begin
            if (imem_req_o) check("req_addr", imem_addr_o, exp_next_pc);
            if (redirect_i) check("redirect_no_req", 32'(imem_req_o), 32'd0);
            if (instr_valid_o && dec_ready_i && !redirect_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(instr_valid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", instr_o, e.instr);
                    check("pc", pc_o, e.pc);
                    check("op", 32'(op_o), 32'(e.instr[31:26]));
                    if (check_lw) begin
                        check("op_lw", 32'(op_o), 32'(OP_LW));
                        check_lw = 1'b0;
                    end
                    if (check_first) begin
                        check("first_pc", pc_o, first_pc);
                        check_first = 1'b0;
                    end
                end
            end
            if (resp && !r.stale && !redirect_i) begin
                exp_q.push_back('{pc: r.addr, instr: mem_word(r.addr)});
            end
            if (imem_req_o && imem_gnt_i) begin
                inflight.push_back('{addr: exp_next_pc, due: cyc + lat, stale: 1'b0});
                last_grant  = exp_next_pc;
                exp_next_pc = exp_next_pc + 32'd4;
                grants++;
            end
            if (redirect_i) begin
                exp_q.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                exp_next_pc = {redirect_pc_i[31:2], 2'b00};
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst_i         = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        dec_ready_i   = 1'b1;
        @(negedge clk);

        // Reset state
        repeat (2) cycle();
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_op", 32'(op_o), 32'd0);
        check("rst_addr", imem_addr_o, RST_PC);

        // Streaming from the reset PC with 1-cycle memory
        rst_i = 1'b1;
        repeat (12) cycle();

        // Grant withheld: address must hold, queue drains
        imem_gnt_i = 1'b0;
        grants     = 0;
        repeat (6) cycle();
        check("gnt_low_grants", 32'(grants), 32'd0);
        check("gnt_low_drained", 32'(instr_valid_o), 32'd0);

        // Decode stalled: exactly DEPTH requests, then credits exhausted
        imem_gnt_i  = 1'b1;
        dec_ready_i = 1'b0;
        grants      = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (instr_valid_o && exp_q.size() > 0) check("stall_head", instr_o, exp_q[0].instr);
        end
        check("stall_grants", 32'(grants), 32'(DEPTH));
        check("stall_req", 32'(imem_req_o), 32'd0);
        dec_ready_i = 1'b1;
        repeat (8) cycle();

        // Redirect with two requests in flight and a same-cycle response
        imem_gnt_i = 1'b0;
        repeat (5) cycle();
        imem_gnt_i  = 1'b1;
        dec_ready_i = 1'b0;
        lat         = 2;
        grants      = 0;
        repeat (2) cycle();
        check("pre_redirect_grants", 32'(grants), 32'd2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0203;
        cycle();
        redirect_i  = 1'b0;
        dec_ready_i = 1'b1;
        lat         = 1;
        check_first = 1'b1;
        first_pc    = 32'h0000_0200;
        #1;
        check("redirect_addr", imem_addr_o, 32'h0000_0200);
        check("redirect_req", 32'(imem_req_o), 32'd1);
        repeat (10) cycle();

        // PC wrap at the top of the address space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        cycle();
        redirect_i  = 1'b0;
        check_first = 1'b1;
        first_pc    = 32'hFFFF_FFFC;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (last_grant == 32'hFFFF_FFFC) break;
        end
        #1;
        check("wrap_addr", imem_addr_o, 32'h0000_0000);
        repeat (6) cycle();

        // Reset mid-stream with a full queue
        dec_ready_i = 1'b0;
        repeat (5) cycle();
        check("full_valid", 32'(instr_valid_o), 32'd1);
        rst_i = 1'b0;
        cycle();
        check("midrst_valid", 32'(instr_valid_o), 32'd0);
        check("midrst_req", 32'(imem_req_o), 32'd0);
        check("midrst_instr", instr_o, 32'd0);
        check("midrst_pc", pc_o, 32'd0);
        check("midrst_op", 32'(op_o), 32'd0);
        cycle();
        rst_i       = 1'b1;
        dec_ready_i = 1'b1;
        check_lw    = 1'b1;
        check_first = 1'b1;
        first_pc    = RST_PC;
        #1;
        check("restart_addr", imem_addr_o, RST_PC);
        check("restart_req", 32'(imem_req_o), 32'd1);
        repeat (10) cycle();

        // Drain: every expected instruction must have been delivered
        imem_gnt_i = 1'b0;
        repeat (6) cycle();
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(instr_valid_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
